// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin arbiter that owns the shared 3-bit mux/demux
// select. It grants one requester at a time for a burst of at most BURST
// cycles, with a one-cycle GAP between bursts so the select never moves under
// an active grant.
module mux8_rr_scheduler #(
  parameter int unsigned BURST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:7] req,
  input  logic       en,
  output logic [2:0] s,
  output logic [0:7] gnt,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned N_REQ    = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  s_q, s_d;
  logic [0:7]        gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              win_found;
  logic [SEL_W-1:0]  win_idx;
  logic [SEL_W-1:0]  cand;

  // Round-robin search starting just after the last winner; last winner is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = SEL_W'(ptr_q + SEL_W'(k));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (en && win_found) begin
          state_d        = GRANT;
          s_d            = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          cnt_d          = CNT_LOAD;
          busy_d         = 1'b1;
        end
      end
      GRANT: begin
        // A request drop and counter expiry on the same edge collapse into one release.
        if (!req[s_q] || (cnt_q == '0)) begin
          state_d = GAP;
          gnt_d   = '0;
          done_d  = 1'b1;
          ptr_d   = s_q;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      GAP: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ptr_q   <= SEL_W'(7);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s    = s_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/mux8_rr_scheduler.md
# mux8_rr_scheduler

Round-robin scheduler that shares the 8-input mux / 8-output demux channel among eight requesters. It arbitrates among the request lines and drives the shared 3-bit select `s` for both the mux and the demux. It grants one requester at a time for a bounded burst. A one-cycle turnaround gap separates bursts, so `s` never changes while any grant is active.

## Interface
- `BURST`, default 8: maximum grant length in cycles. Legal range 1..16. The counter is 4 bits wide.

- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `req`  in  [0:7]: request lines; `req[i]` is set by requester i.
- `en`  in  1: global enable; gates new grants only.
- `s`  out  [2:0]: select for the mux/demux; index of the current or last granted requester.
- `gnt`  out  [0:7]: grant vector; one-hot or all zero.
- `busy`  out  1: high when the state is not IDLE.
- `done`  out  1: one-cycle pulse at the end of each burst.

## Operation
- States: IDLE, GRANT, GAP. All outputs are registered.
- Internal signals:
  - `ptr`: last winner, 3 bits.
  - `cnt`: burst counter, 4 bits.
- Reset values:
  - state = IDLE
  - s = 0
  - gnt = 0
  - busy = 0
  - done = 0
  - ptr = 7, so the first search starts at index 0
  - cnt = 0
- IDLE:
  - Outputs: gnt = 0, busy = 0; `s` holds its value.
  - If `en` = 1 and any `req` bit is 1: the winner is the first set bit in search order ptr+1, ptr+2, …, ptr+8 (mod 8). The last winner is searched last.
  - On that edge: s ← winner, gnt ← one-hot(winner), cnt ← BURST-1, state ← GRANT.
- GRANT:
  - Outputs: busy = 1; `gnt` and `s` are stable.
  - At each edge, the burst is released if `req[s]` = 0 or `cnt` = 0. Otherwise cnt ← cnt-1.
  - On release: gnt ← 0, done ← 1, ptr ← s, state ← GAP.
  - A request drop and `cnt` = 0 on the same edge cause a single release with a single `done` pulse.
- GAP:
  - Lasts exactly one cycle, then state ← IDLE.
  - Outputs: gnt = 0, busy = 1, done = 1 during this cycle; `s` holds.
  - `done` is 0 in every other state.
- `en` deasserted during GRANT does not abort the burst. It only blocks the next arbitration in IDLE.
- Requests of non-granted requesters are ignored during GRANT and GAP. They are not latched; a request must still be high when IDLE samples it.
- A single persistent requester wins again after each gap.
- Reset asserted mid-burst: all registers return to their reset values on that edge. `gnt` is 0 in the following cycle, and `ptr` returns to 7.

## Timing
- Grant latency: `req` sampled high in IDLE at edge t → `gnt`, `s` and `busy` valid from edge t until the release edge.
- Full burst: `gnt` is high for exactly BURST cycles.
- Early release: `gnt` is high for N cycles, where edge N is the first GRANT edge that samples `req[s]` = 0. The minimum is 1 cycle.
- `done` is high during the single cycle immediately after `gnt` falls.
- Back-to-back bursts: after `gnt` falls, there is 1 GAP cycle and 1 IDLE cycle, then the next grant. The minimum is 2 cycles with `gnt` = 0 between bursts.
- `s` changes only on the IDLE→GRANT edge, never while `gnt` ≠ 0.
- BURST = 1: every grant lasts 1 cycle and the period is 3 cycles.

## Test plan
1. Reset: hold `rst` = 1 for 2 cycles with `req` = all ones and `en` = 1 → s = 0, gnt = 0, busy = 0, done = 0 throughout. First grant is `gnt[0]` one cycle after `rst` falls.
2. Single requester: BURST = 8, `req[2]` held, `en` = 1 → s = 2, `gnt[2]` high 8 cycles, `done` high 1 cycle, `gnt` low 2 cycles, then `gnt[2]` again.
3. Round-robin fairness: all 8 `req` bits held, BURST = 4 → grants in order 0,1,2,3,4,5,6,7,0. Each lasts 4 cycles with a 2-cycle gap; `gnt` is never multi-hot.
4. Early release: `req[5]` only, dropped so the 3rd GRANT edge samples it low → `gnt[5]` high 3 cycles, one `done` pulse, `ptr` = 5. Then `req[5]` and `req[1]` are raised → next winner is 1.
5. Enable gating: `en` = 0 with `req[3]` high for 10 cycles → gnt = 0 and busy = 0 throughout. Then `en` = 1 for one cycle and 0 on the next edge → `gnt[3]` completes the full BURST cycles and no second grant follows.
6. Reset mid-burst: `rst` pulsed in the 4th cycle of a `gnt[6]` burst → gnt = 0, s = 0, done = 0 in the next cycle. With `req[6]` and `req[2]` held afterwards, the first grant goes to 2.
